// File: rtl/quad_step_decoder.sv
// Quadrature A/B front end: two-flop synchroniser, stability filter, Gray-code
// decoder and saturating position counter with step/direction/limit/error pulses.
module quad_step_decoder #(
  parameter int WIDTH      = 3,
  parameter int FILTER_LEN = 4   // legal range 1..15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             phase_a,
  input  logic             phase_b,
  output logic             step,
  output logic             up_down,
  output logic [WIDTH-1:0] count,
  output logic             limit,
  output logic             error
);

  typedef enum logic {
    ST_INIT,
    ST_TRACK
  } state_t;

  localparam logic [3:0]       FLT_LAST  = 4'(FILTER_LEN - 1);
  localparam logic [WIDTH-1:0] COUNT_MAX = '1;
  localparam logic [WIDTH-1:0] COUNT_ONE = WIDTH'(1);

  state_t     state, state_nxt;
  logic [1:0] sync_meta, sync, sync_prev;
  logic [1:0] filtered, filtered_nxt;
  logic [3:0] flt_cnt, flt_cnt_nxt;
  logic       stable;

  // Decoded result of an accept, presented to the output stage one edge later.
  logic       evt_valid, evt_valid_nxt;
  logic       evt_up, evt_up_nxt;
  logic       evt_illegal, evt_illegal_nxt;

  // Forward Gray sequence: 00 -> 01 -> 11 -> 10 -> 00.
  function automatic logic [1:0] gray_fwd(input logic [1:0] v);
    case (v)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // NOTE: this reset is synchronous, so it appears only inside the clocked
  // branch and rst must be held across at least one rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= '0;
      sync      <= '0;
      sync_prev <= '0;
    end else begin
      // NOTE: non-blocking assignments make this a true three-stage shift;
      // blocking ones would collapse it into a single flop.
      sync_meta <= {phase_a, phase_b};
      sync      <= sync_meta;
      sync_prev <= sync;
    end
  end

  assign stable = (sync == sync_prev);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_INIT;
      filtered    <= '0;
      flt_cnt     <= '0;
      evt_valid   <= 1'b0;
      evt_up      <= 1'b0;
      evt_illegal <= 1'b0;
    end else begin
      state       <= state_nxt;
      filtered    <= filtered_nxt;
      flt_cnt     <= flt_cnt_nxt;
      evt_valid   <= evt_valid_nxt;
      evt_up      <= evt_up_nxt;
      evt_illegal <= evt_illegal_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so that no path
    // through the case statement can infer a latch.
    state_nxt       = state;
    filtered_nxt    = filtered;
    flt_cnt_nxt     = flt_cnt;
    evt_valid_nxt   = 1'b0;
    evt_up_nxt      = 1'b0;
    evt_illegal_nxt = 1'b0;

    case (state)
      ST_INIT: begin
        // Adopt whatever the encoder sits at once it has settled; no event.
        if (!stable) begin
          flt_cnt_nxt = '0;
        end else if (flt_cnt == FLT_LAST) begin
          filtered_nxt = sync;
          flt_cnt_nxt  = '0;
          state_nxt    = ST_TRACK;
        end else begin
          flt_cnt_nxt = flt_cnt + 4'd1;
        end
      end

      default: begin
        if (!stable || sync == filtered) begin
          flt_cnt_nxt = '0;
        end else if (flt_cnt == FLT_LAST) begin
          // Candidate accepted: filtered always follows, even when illegal.
          filtered_nxt    = sync;
          flt_cnt_nxt     = '0;
          evt_valid_nxt   = 1'b1;
          evt_illegal_nxt = ((sync ^ filtered) == 2'b11);
          evt_up_nxt      = (sync == gray_fwd(filtered));
        end else begin
          flt_cnt_nxt = flt_cnt + 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step    <= 1'b0;
      up_down <= 1'b0;
      count   <= '0;
      limit   <= 1'b0;
      error   <= 1'b0;
    end else begin
      step  <= 1'b0;
      limit <= 1'b0;
      error <= 1'b0;
      // Events arriving while disabled are dropped, not deferred.
      if (evt_valid && enable) begin
        if (evt_illegal) begin
          error <= 1'b1;
        end else begin
          step    <= 1'b1;
          up_down <= evt_up;
          if (evt_up) begin
            if (count == COUNT_MAX) limit <= 1'b1;
            else                    count <= count + COUNT_ONE;
          end else begin
            if (count == '0) limit <= 1'b1;
            else             count <= count - COUNT_ONE;
          end
        end
      end
    end
  end

endmodule
